// File: rtl/da.sv
// Bit-serial distributed-arithmetic engine: eight 256x19 coefficient ROMs,
// one ROM read per RUN cycle, then a shift-accumulate into a 38-bit result.
module da (
    input  logic        clk,
    input  logic        resetn,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  A7,
    input  logic [7:0]  A6,
    input  logic [7:0]  A5,
    input  logic [7:0]  A4,
    input  logic [7:0]  A3,
    input  logic [7:0]  A2,
    input  logic [7:0]  A1,
    input  logic [7:0]  A0,
    input  logic        CLOAD,
    input  logic [10:0] CADDR,
    input  logic [18:0] CIN,
    output logic [37:0] ACC_OUT,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic        rst_l;
    logic [7:0]  a_l [8];
    logic [21:0] sum;
    logic [18:0] rom [2048];
    logic [18:0] rd;
    logic [21:0] rd_x;
    logic [37:0] sum_x;

    assign rd    = rom[{cnt, a_l[cnt]}];
    assign rd_x  = {{3{rd[18]}}, rd};
    assign sum_x = {{16{sum[21]}}, sum};
    assign done  = (state == DONE);

    // Coefficient store is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (CLOAD && state == IDLE)
            rom[CADDR] <= CIN;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            rst_l   <= 1'b0;
            sum     <= 22'd0;
            ACC_OUT <= 38'd0;
            for (int k = 0; k < 8; k++)
                a_l[k] <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_l[0] <= A0;
                        a_l[1] <= A1;
                        a_l[2] <= A2;
                        a_l[3] <= A3;
                        a_l[4] <= A4;
                        a_l[5] <= A5;
                        a_l[6] <= A6;
                        a_l[7] <= A7;
                        rst_l  <= reset;
                        sum    <= 22'd0;
                        cnt    <= 3'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum <= sum + rd_x;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= ACC;
                end
                ACC: begin
                    if (rst_l)
                        ACC_OUT <= sum_x;
                    else
                        ACC_OUT <= (ACC_OUT << 1) + sum_x;
                    state <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_da.sv
// Directed bench for da: latency, sign handling, 16-step word accumulation,
// ignored start/CLOAD while busy, and mid-step asynchronous abort.
module tb_da;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a [8];
    logic        cload = 1'b0;
    logic [10:0] caddr = 11'd0;
    logic [18:0] cin = 19'd0;
    logic [37:0] ACC_OUT;
    logic        done;

    logic [18:0] mdl [2048];
    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    da u_da (
        .clk(clk), .resetn(resetn), .reset(reset), .start(start),
        .A7(a[7]), .A6(a[6]), .A5(a[5]), .A4(a[4]),
        .A3(a[3]), .A2(a[2]), .A1(a[1]), .A0(a[0]),
        .CLOAD(cload), .CADDR(caddr), .CIN(cin),
        .ACC_OUT(ACC_OUT), .done(done)
    );

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] k, input logic [7:0] e,
                      input logic [18:0] v);
        @(negedge clk);
        cload = 1'b1;
        caddr = {k, e};
        cin   = v;
        mdl[{k, e}] = v;
        @(posedge clk);
        #1 cload = 1'b0;
    endtask

    function automatic logic [21:0] slice_sum();
        logic [21:0] s = 22'd0;
        logic [18:0] v;
        for (int k = 0; k < 8; k++) begin
            v = mdl[{k[2:0], a[k]}];
            s = s + {{3{v[18]}}, v};
        end
        return s;
    endfunction

    // One step; inj>=0 pokes start+CLOAD (ROM0[FF]=100) at that RUN cycle.
    task automatic run(input string tag, input logic rst, input int inj,
                       input logic signed [63:0] exp);
        int lat;
        @(negedge clk);
        start = 1'b1;
        reset = rst;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 8; k++)
            a[k] = 8'h5A;
        lat = 0;
        while (!done && lat < 20) begin
            if (lat == inj) begin
                start = 1'b1;
                cload = 1'b1;
                caddr = 11'h0FF;
                cin   = 19'd100;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cload = 1'b0;
            lat++;
        end
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_acc"}, $signed(ACC_OUT), exp);
        @(posedge clk);
        #1 chk({tag, "_done_drop"}, done, 0);
    endtask

    initial begin
        logic [37:0] acc_m;
        logic [37:0] ref2;
        logic [21:0] s;
        int hits;

        for (int k = 0; k < 8; k++)
            a[k] = 8'h00;

        #1;
        chk("rst_acc", $signed(ACC_OUT), 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_acc", $signed(ACC_OUT), 0);
        chk("idle_done", done, 0);

        for (int k = 0; k < 8; k++)
            wr(k[2:0], 8'hFF, 19'd1);
        for (int k = 0; k < 8; k++)
            a[k] = 8'hFF;
        run("ones", 1'b1, -1, 8);

        for (int k = 0; k < 8; k++)
            wr(k[2:0], 8'h00, 19'd0);
        wr(3'd3, 8'h05, 19'h40000);
        for (int k = 0; k < 8; k++)
            a[k] = 8'h00;
        a[3] = 8'h05;
        run("neg1", 1'b1, -1, -262144);
        for (int k = 0; k < 8; k++)
            a[k] = 8'h00;
        a[3] = 8'h05;
        run("neg2", 1'b0, -1, -786432);

        for (int i = 0; i < 2048; i++)
            wr(i[10:8], i[7:0], 19'($urandom));
        acc_m = 38'd0;
        ref2  = 38'd0;
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 8; k++)
                a[k] = 8'($urandom);
            s = slice_sum();
            ref2 = ref2 + ({{16{s[21]}}, s} << (15 - j));
            if (j == 0)
                acc_m = {{16{s[21]}}, s};
            else
                acc_m = (acc_m << 1) + {{16{s[21]}}, s};
            run("word", (j == 0), -1, $signed(acc_m));
            @(posedge clk);
        end
        chk("word_final", $signed(ACC_OUT), $signed(ref2));

        for (int k = 0; k < 8; k++)
            wr(k[2:0], 8'hFF, 19'd1);
        for (int k = 0; k < 8; k++)
            a[k] = 8'hFF;
        run("busy", 1'b1, 3, 8);
        for (int k = 0; k < 8; k++)
            a[k] = 8'hFF;
        run("busy_rom", 1'b1, -1, 8);

        for (int k = 0; k < 8; k++)
            a[k] = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort_acc", $signed(ACC_OUT), 0);
        chk("abort_done", done, 0);
        #1 resetn = 1'b1;
        hits = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1 if (done) hits++;
        end
        chk("abort_no_done", hits, 0);
        chk("abort_hold", $signed(ACC_OUT), 0);
        for (int k = 0; k < 8; k++)
            a[k] = 8'hFF;
        run("after_abort", 1'b1, -1, 8);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
